// File: rtl/s27_pkg.sv
// Shared constants, state encoding and counter helper for the s27 scan sequencer.
package s27_pkg;

    localparam int NUM_FF = 3;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } state_e;

    // True on the final cycle of a phase lasting len cycles.
    function automatic logic cnt_last(input logic [CNT_W-1:0] cnt, input int unsigned len);
        return (cnt == CNT_W'(len - 32'd1));
    endfunction

endpackage

// File: rtl/s27_scan_dff.sv
// One mux-D scan flop: se=1 takes the serial input, se=0 takes the functional d.
module s27_scan_dff (
    input  logic clk,
    input  logic rst,
    input  logic se,
    input  logic si,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    // Scan/functional input select.
    always_comb begin
        q_d = 1'b0;
        if (se) begin
            q_d = si;
        end else begin
            q_d = d;
        end
    end

    // Storage bit with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/s27_scan_seq.sv
// s27 state register with a built-in one-shot scan controller:
// shift in, capture for CAPTURE_CYCLES clocks, shift out, then pulse test_done.
module s27_scan_seq
    import s27_pkg::*;
#(
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic func_en,
    input  logic ns_g10,
    input  logic ns_g11,
    input  logic ns_g13,
    input  logic po_g17,
    output logic ps_g5,
    output logic ps_g6,
    output logic ps_g7,
    input  logic test_start,
    input  logic scan_in,
    output logic scan_out,
    output logic scan_valid,
    output logic g17_cap,
    output logic test_busy,
    output logic test_done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               g17_cap_q, g17_cap_d;
    logic               scan_valid_q, scan_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               se_s;
    logic               load_s;
    logic [NUM_FF-1:0]  ns_s;
    logic [NUM_FF-1:0]  ff_q;
    logic [NUM_FF-1:0]  si_s;
    logic [NUM_FF-1:0]  d_s;

    assign ns_s = {ns_g13, ns_g11, ns_g10};

    // Chain wiring: scan_in -> ff0 -> ff1 -> ff2; hold is a d=q loop-back.
    always_comb begin
        si_s = {ff_q[NUM_FF-2:0], scan_in};
        d_s  = ff_q;
        if (load_s) begin
            d_s = ns_s;
        end else begin
            d_s = ff_q;
        end
    end

    for (genvar i = 0; i < NUM_FF; i++) begin : g_ff
        s27_scan_dff u_ff (
            .clk (clk),
            .rst (rst),
            .se  (se_s),
            .si  (si_s[i]),
            .d   (d_s[i]),
            .q   (ff_q[i])
        );
    end

    // Next-state, counter and chain-control decode; counter clears on every state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        g17_cap_d = g17_cap_q;
        se_s      = 1'b0;
        load_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (test_start) begin
                    state_d = SHIFT_IN;
                    cnt_d   = '0;
                end else if (func_en) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            SHIFT_IN: begin
                se_s = 1'b1;
                if (cnt_last(cnt_q, NUM_FF)) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                load_s = 1'b1;
                if (cnt_last(cnt_q, CAPTURE_CYCLES)) begin
                    g17_cap_d = po_g17;
                    state_d   = SHIFT_OUT;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT_OUT: begin
                se_s = 1'b1;
                if (cnt_last(cnt_q, NUM_FF)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        scan_valid_d = (state_d == SHIFT_OUT);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    // Controller state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            g17_cap_q    <= 1'b0;
            scan_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            g17_cap_q    <= g17_cap_d;
            scan_valid_q <= scan_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ps_g5      = ff_q[0];
    assign ps_g6      = ff_q[1];
    assign ps_g7      = ff_q[2];
    assign scan_out   = ff_q[NUM_FF-1];
    assign scan_valid = scan_valid_q;
    assign g17_cap    = g17_cap_q;
    assign test_busy  = busy_q;
    assign test_done  = done_q;

endmodule
